// File: rtl/five_sons_pkg.sv
// Shared encodings for the five-in-a-row engine: board geometry, cell and status codes,
// controller states, scan directions and the (x,y) -> board bit offset helper.
package five_sons_pkg;

  localparam int BOARD_DIM  = 16;
  localparam int CELL_COUNT = BOARD_DIM * BOARD_DIM;
  localparam int BOARD_BITS = CELL_COUNT * 2;
  localparam int WIN_LEN    = 5;

  localparam logic [1:0] CELL_EMPTY = 2'b11;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;

  localparam logic [1:0] ST_PLAY      = 2'b00;
  localparam logic [1:0] ST_BLACK_WIN = 2'b01;
  localparam logic [1:0] ST_WHITE_WIN = 2'b10;
  localparam logic [1:0] ST_DRAW      = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLACE   = 3'd1,
    S_SCAN    = 3'd2,
    S_RESOLVE = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    DIR_E  = 2'd0,
    DIR_S  = 2'd1,
    DIR_SE = 2'd2,
    DIR_NE = 2'd3
  } dir_t;

  // Cell (x,y) lives at bit x*2 + y*32 of the flattened board.
  function automatic logic [8:0] CO_TO_OFFSET(input logic [3:0] x, input logic [3:0] y);
    return {y, x, 1'b0};
  endfunction

endpackage

// File: rtl/five_sons_line_scan.sv
// Sequential five-in-a-row checker: probes one board cell per cycle around an anchor stone,
// walking E, S, SE, NE, each first toward +dir and then toward -dir.
module five_sons_line_scan
  import five_sons_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [3:0]            i_anchor_x,
  input  logic [3:0]            i_anchor_y,
  input  logic [1:0]            i_colour,
  input  logic [BOARD_BITS-1:0] i_board,
  output logic                  o_done,
  output logic                  o_win,
  output logic                  o_active
);

  // Handshake: i_start is a one-cycle request; anchor, colour and board must hold steady
  // until o_done, a one-cycle combinational pulse that is valid together with o_win.

  logic              r_active;
  dir_t              r_dir;
  logic              r_neg;
  logic signed [4:0] r_x;
  logic signed [4:0] r_y;
  logic [3:0]        r_cnt;
  logic [2:0]        r_steps;

  logic signed [4:0] w_dx;
  logic signed [4:0] w_dy;
  logic signed [4:0] w_px;
  logic signed [4:0] w_py;
  logic              w_inb;
  logic [8:0]        w_off;
  logic [1:0]        w_cell;
  logic              w_match;
  logic [3:0]        w_cnt_n;
  logic              w_win;
  logic              w_half_end;
  logic              w_last;

  always_comb begin
    w_dx = 5'sd0;
    w_dy = 5'sd0;
    case (r_dir)
      DIR_E:   begin w_dx = 5'sd1; w_dy = 5'sd0;  end
      DIR_S:   begin w_dx = 5'sd0; w_dy = 5'sd1;  end
      DIR_SE:  begin w_dx = 5'sd1; w_dy = 5'sd1;  end
      DIR_NE:  begin w_dx = 5'sd1; w_dy = -5'sd1; end
      default: begin w_dx = 5'sd0; w_dy = 5'sd0;  end
    endcase
    if (r_neg) begin
      w_dx = -w_dx;
      w_dy = -w_dy;
    end
    w_px = r_x + w_dx;
    w_py = r_y + w_dy;
    // 16 wraps to -16 and -1 stays negative, so bit 4 alone flags off-board.
    w_inb      = !w_px[4] && !w_py[4];
    w_off      = CO_TO_OFFSET(w_px[3:0], w_py[3:0]);
    w_cell     = i_board[w_off +: 2];
    w_match    = w_inb && (w_cell == i_colour);
    w_cnt_n    = r_cnt + 4'd1;
    w_win      = r_active && w_match && (w_cnt_n >= 4'(WIN_LEN));
    w_half_end = r_active && !w_win &&
                 (!w_match || ((r_steps + 3'd1) == 3'(WIN_LEN - 1)));
    w_last     = w_half_end && r_neg && (r_dir == DIR_NE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_active <= 1'b0;
      r_dir    <= DIR_E;
      r_neg    <= 1'b0;
      r_x      <= 5'sd0;
      r_y      <= 5'sd0;
      r_cnt    <= 4'd0;
      r_steps  <= 3'd0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_dir    <= DIR_E;
      r_neg    <= 1'b0;
      r_x      <= {1'b0, i_anchor_x};
      r_y      <= {1'b0, i_anchor_y};
      r_cnt    <= 4'd1;
      r_steps  <= 3'd0;
    end else if (r_active) begin
      if (w_win || w_last) begin
        r_active <= 1'b0;
      end else if (w_half_end) begin
        r_x     <= {1'b0, i_anchor_x};
        r_y     <= {1'b0, i_anchor_y};
        r_steps <= 3'd0;
        if (w_match) r_cnt <= w_cnt_n;
        if (!r_neg) begin
          r_neg <= 1'b1;
        end else begin
          // New direction: the count restarts with just the anchor stone.
          r_neg <= 1'b0;
          r_dir <= dir_t'(r_dir + 2'd1);
          r_cnt <= 4'd1;
        end
      end else begin
        r_x     <= w_px;
        r_y     <= w_py;
        r_cnt   <= w_cnt_n;
        r_steps <= r_steps + 3'd1;
      end
    end
  end

  assign o_done   = w_win || w_last;
  assign o_win    = w_win;
  assign o_active = r_active;

endmodule

// File: rtl/five_sons_game_ctrl.sv
// Gomoku game controller: pointer movement, alternating stone placement and win resolution.
// Optional FIVE_SONS_DRAW_DETECT_EN adds a stone counter that declares a draw on a full board.
module five_sons_game_ctrl
  import five_sons_pkg::*;
#(
  parameter logic [3:0] START_X = 4'd4,
  parameter logic [3:0] START_Y = 4'd6
) (
  input  logic                  Clck,
  input  logic                  Reset,
  input  logic                  mv_left,
  input  logic                  mv_right,
  input  logic                  mv_up,
  input  logic                  mv_down,
  input  logic                  place,
  output logic [BOARD_BITS-1:0] board,
  output logic [1:0]            gaming_status,
  output logic [3:0]            pointer_loc_x,
  output logic [3:0]            pointer_loc_y,
  output logic                  turn,
  output logic                  busy,
  output state_t                o_dbg_state
);

  state_t                r_state;
  logic [BOARD_BITS-1:0] r_board;
  logic [1:0]            r_status;
  logic [3:0]            r_px;
  logic [3:0]            r_py;
  logic                  r_turn;
  logic                  r_busy;
  logic [3:0]            r_anchor_x;
  logic [3:0]            r_anchor_y;
  logic [1:0]            r_colour;
  logic                  r_win;
`ifdef FIVE_SONS_DRAW_DETECT_EN
  logic [8:0]            r_stones;
`endif

  logic [3:0] w_nx;
  logic [3:0] w_ny;
  logic [1:0] w_ptr_cell;
  logic       w_place_ok;
  logic       w_scan_start;
  logic       w_scan_done;
  logic       w_scan_win;
  logic       w_scan_active;

  // Saturating pointer step; a single move per cycle with left > right > up > down.
  always_comb begin
    w_nx = r_px;
    w_ny = r_py;
    if (mv_left) begin
      if (r_px != 4'd0) w_nx = r_px - 4'd1;
    end else if (mv_right) begin
      if (r_px != 4'(BOARD_DIM - 1)) w_nx = r_px + 4'd1;
    end else if (mv_up) begin
      if (r_py != 4'd0) w_ny = r_py - 4'd1;
    end else if (mv_down) begin
      if (r_py != 4'(BOARD_DIM - 1)) w_ny = r_py + 4'd1;
    end
  end

  assign w_ptr_cell   = r_board[CO_TO_OFFSET(r_px, r_py) +: 2];
  assign w_place_ok   = place && (w_ptr_cell == CELL_EMPTY);
  assign w_scan_start = (r_state == S_PLACE);

  five_sons_line_scan u_scan (
    .i_clk      (Clck),
    .i_rst      (Reset),
    .i_start    (w_scan_start),
    .i_anchor_x (r_anchor_x),
    .i_anchor_y (r_anchor_y),
    .i_colour   (r_colour),
    .i_board    (r_board),
    .o_done     (w_scan_done),
    .o_win      (w_scan_win),
    .o_active   (w_scan_active)
  );

  always_ff @(posedge Clck) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_board    <= '1;
      r_status   <= ST_PLAY;
      r_px       <= START_X;
      r_py       <= START_Y;
      r_turn     <= 1'b0;
      r_busy     <= 1'b0;
      r_anchor_x <= 4'd0;
      r_anchor_y <= 4'd0;
      r_colour   <= CELL_BLACK;
      r_win      <= 1'b0;
`ifdef FIVE_SONS_DRAW_DETECT_EN
      r_stones   <= 9'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_place_ok) begin
            r_anchor_x <= r_px;
            r_anchor_y <= r_py;
            r_colour   <= r_turn ? CELL_WHITE : CELL_BLACK;
            r_busy     <= 1'b1;
            r_state    <= S_PLACE;
          end else begin
            r_px <= w_nx;
            r_py <= w_ny;
          end
        end
        S_PLACE: begin
          r_board[CO_TO_OFFSET(r_anchor_x, r_anchor_y) +: 2] <= r_colour;
          r_win   <= 1'b0;
          r_state <= S_SCAN;
`ifdef FIVE_SONS_DRAW_DETECT_EN
          r_stones <= r_stones + 9'd1;
`endif
        end
        S_SCAN: begin
          if (w_scan_done) begin
            r_win   <= w_scan_win;
            r_state <= S_RESOLVE;
          end
        end
        S_RESOLVE: begin
          r_busy <= 1'b0;
          if (r_win) begin
            r_status <= (r_colour == CELL_WHITE) ? ST_WHITE_WIN : ST_BLACK_WIN;
            r_state  <= S_OVER;
`ifdef FIVE_SONS_DRAW_DETECT_EN
          end else if (r_stones == 9'(CELL_COUNT)) begin
            r_status <= ST_DRAW;
            r_state  <= S_OVER;
`endif
          end else begin
            r_turn  <= ~r_turn;
            r_state <= S_IDLE;
          end
        end
        S_OVER: begin
          // Game finished: the pointer still roams but the board is frozen.
          r_px <= w_nx;
          r_py <= w_ny;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign board         = r_board;
  assign gaming_status = r_status;
  assign pointer_loc_x = r_px;
  assign pointer_loc_y = r_py;
  assign turn          = r_turn;
  assign busy          = r_busy;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_five_sons_game_ctrl.sv
// Directed bench for five_sons_game_ctrl: pointer, wins, edge runs, reset mid-scan and full board.
// Draw expectations follow FIVE_SONS_DRAW_DETECT_EN.
module tb_five_sons_game_ctrl;
  import five_sons_pkg::*;

  localparam logic [4:0] P_LEFT  = 5'b10000;
  localparam logic [4:0] P_RIGHT = 5'b01000;
  localparam logic [4:0] P_UP    = 5'b00100;
  localparam logic [4:0] P_DOWN  = 5'b00010;
  localparam logic [4:0] P_PLACE = 5'b00001;

  logic         Clck = 1'b0;
  logic         Reset = 1'b1;
  logic         mv_left = 1'b0, mv_right = 1'b0, mv_up = 1'b0, mv_down = 1'b0, place = 1'b0;
  logic [511:0] board;
  logic [1:0]   gaming_status;
  logic [3:0]   pointer_loc_x, pointer_loc_y;
  logic         turn, busy;
  state_t       dbg_state;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [511:0] exp_board;
  logic [511:0] all_empty;
  int           exp_x, exp_y;
  logic         exp_turn;

  always #5 Clck = ~Clck;

  five_sons_game_ctrl dut (
    .Clck          (Clck),
    .Reset         (Reset),
    .mv_left       (mv_left),
    .mv_right      (mv_right),
    .mv_up         (mv_up),
    .mv_down       (mv_down),
    .place         (place),
    .board         (board),
    .gaming_status (gaming_status),
    .pointer_loc_x (pointer_loc_x),
    .pointer_loc_y (pointer_loc_y),
    .turn          (turn),
    .busy          (busy),
    .o_dbg_state   (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge Clck);
    Reset = 1'b1;
    {mv_left, mv_right, mv_up, mv_down, place} = 5'b0;
    @(negedge Clck);
    Reset = 1'b0;
    exp_board = all_empty;
    exp_x = 4;
    exp_y = 6;
    exp_turn = 1'b0;
  endtask

  task automatic pulse(input logic [4:0] m);
    @(negedge Clck);
    {mv_left, mv_right, mv_up, mv_down, place} = m;
    @(negedge Clck);
    {mv_left, mv_right, mv_up, mv_down, place} = 5'b0;
  endtask

  task automatic move_to(input int x, input int y);
    while (exp_x > x) begin pulse(P_LEFT);  exp_x--; end
    while (exp_x < x) begin pulse(P_RIGHT); exp_x++; end
    while (exp_y > y) begin pulse(P_UP);    exp_y--; end
    while (exp_y < y) begin pulse(P_DOWN);  exp_y++; end
  endtask

  // lat = negedges from place acceptance until busy drops; -1 on timeout.
  task automatic place_at(input int x, input int y, output int lat, output bit seen);
    move_to(x, y);
    pulse(P_PLACE);
    seen = busy;
    lat = 1;
    while (busy && lat < 100) begin
      @(negedge Clck);
      lat++;
    end
    if (busy) lat = -1;
  endtask

  task automatic model_place(input int x, input int y, input bit win);
    exp_board[x*2 + y*32 +: 2] = exp_turn ? CELL_WHITE : CELL_BLACK;
    if (!win) exp_turn = ~exp_turn;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++; if (board !== all_empty) begin n_fail++; $display("FAIL reset_board: got %h want all ones", board); end
    n_checks++; if (gaming_status !== ST_PLAY) begin n_fail++; $display("FAIL reset_status: got %b want 00", gaming_status); end
    n_checks++; if (pointer_loc_x !== 4'd4) begin n_fail++; $display("FAIL reset_ptr_x: got %0d want 4", pointer_loc_x); end
    n_checks++; if (pointer_loc_y !== 4'd6) begin n_fail++; $display("FAIL reset_ptr_y: got %0d want 6", pointer_loc_y); end
    n_checks++; if (turn !== 1'b0) begin n_fail++; $display("FAIL reset_turn: got %b want 0", turn); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_pointer();
    do_reset();
    for (int i = 0; i < 3; i++) pulse(P_LEFT);
    for (int i = 0; i < 2; i++) pulse(P_UP);
    n_checks++; if (pointer_loc_x !== 4'd1) begin n_fail++; $display("FAIL ptr_move_x: got %0d want 1", pointer_loc_x); end
    n_checks++; if (pointer_loc_y !== 4'd4) begin n_fail++; $display("FAIL ptr_move_y: got %0d want 4", pointer_loc_y); end
    for (int i = 0; i < 5; i++) pulse(P_LEFT);
    n_checks++; if (pointer_loc_x !== 4'd0) begin n_fail++; $display("FAIL ptr_sat_left: got %0d want 0", pointer_loc_x); end
    for (int i = 0; i < 17; i++) pulse(P_RIGHT);
    n_checks++; if (pointer_loc_x !== 4'd15) begin n_fail++; $display("FAIL ptr_sat_right: got %0d want 15", pointer_loc_x); end
    for (int i = 0; i < 13; i++) pulse(P_DOWN);
    n_checks++; if (pointer_loc_y !== 4'd15) begin n_fail++; $display("FAIL ptr_sat_down: got %0d want 15", pointer_loc_y); end
    pulse(P_LEFT | P_RIGHT);
    n_checks++; if (pointer_loc_x !== 4'd14) begin n_fail++; $display("FAIL ptr_prio_lr: got %0d want 14", pointer_loc_x); end
    pulse(P_UP | P_DOWN);
    n_checks++; if (pointer_loc_y !== 4'd14) begin n_fail++; $display("FAIL ptr_prio_ud: got %0d want 14", pointer_loc_y); end
    exp_x = 14;
    exp_y = 14;
  endtask

  task automatic test_black_row_win();
    int lat;
    bit seen;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      place_at(i / 2, i % 2, lat, seen);
      model_place(i / 2, i % 2, i == 8);
      if (i < 8) begin
        n_checks++; if (turn !== exp_turn || gaming_status !== ST_PLAY) begin
          n_fail++; $display("FAIL row_turn_%0d: got turn %b status %b want turn %b status 00", i, turn, gaming_status, exp_turn);
        end
      end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL row_busy: got busy 0 want 1 after place"); end
    n_checks++; if (lat < 1 || lat > 35) begin n_fail++; $display("FAIL row_latency: got %0d want 1..35", lat); end
    n_checks++; if (gaming_status !== ST_BLACK_WIN) begin n_fail++; $display("FAIL row_status: got %b want 01", gaming_status); end
    n_checks++; if (turn !== 1'b0) begin n_fail++; $display("FAIL row_turn_win: got %b want 0", turn); end
    n_checks++; if (board !== exp_board) begin n_fail++; $display("FAIL row_board: got %h want %h", board, exp_board); end
    place_at(6, 6, lat, seen);
    n_checks++; if (seen || board !== exp_board) begin n_fail++; $display("FAIL over_place_ignored: got busy %b board %h", seen, board); end
    n_checks++; if (gaming_status !== ST_BLACK_WIN) begin n_fail++; $display("FAIL over_status: got %b want 01", gaming_status); end
    n_checks++; if (pointer_loc_x !== 4'd6 || pointer_loc_y !== 4'd6) begin
      n_fail++; $display("FAIL over_ptr: got (%0d,%0d) want (6,6)", pointer_loc_x, pointer_loc_y);
    end
  endtask

  task automatic test_diag_white_win();
    int xs[10] = '{0, 5, 2, 6, 4, 8, 6, 9, 8, 7};
    int ys[10] = '{15, 5, 15, 6, 15, 8, 15, 9, 15, 7};
    int lat;
    bit seen;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      place_at(xs[i], ys[i], lat, seen);
      model_place(xs[i], ys[i], i == 9);
      if (i == 8) begin
        n_checks++; if (gaming_status !== ST_PLAY || turn !== 1'b1) begin
          n_fail++; $display("FAIL diag_pre: got status %b turn %b want 00/1", gaming_status, turn);
        end
      end
    end
    n_checks++; if (lat < 1 || lat > 35) begin n_fail++; $display("FAIL diag_latency: got %0d want 1..35", lat); end
    n_checks++; if (gaming_status !== ST_WHITE_WIN) begin n_fail++; $display("FAIL diag_status: got %b want 10", gaming_status); end
    n_checks++; if (board !== exp_board) begin n_fail++; $display("FAIL diag_board: got %h want %h", board, exp_board); end
  endtask

  task automatic test_edge_run();
    int xs[11] = '{0, 5, 0, 7, 12, 9, 13, 11, 14, 13, 15};
    int ys[11] = '{3, 10, 4, 10, 3, 10, 3, 10, 3, 10, 3};
    int lat;
    bit seen;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      place_at(xs[i], ys[i], lat, seen);
      model_place(xs[i], ys[i], 1'b0);
    end
    n_checks++; if (!seen || lat < 1 || lat > 35) begin n_fail++; $display("FAIL edge_busy: got seen %b lat %0d want 1/1..35", seen, lat); end
    n_checks++; if (gaming_status !== ST_PLAY) begin n_fail++; $display("FAIL edge_status: got %b want 00", gaming_status); end
    n_checks++; if (turn !== 1'b1) begin n_fail++; $display("FAIL edge_turn: got %b want 1", turn); end
    n_checks++; if (board !== exp_board) begin n_fail++; $display("FAIL edge_board: got %h want %h", board, exp_board); end
  endtask

  task automatic test_occupied_and_reset();
    int lat;
    bit seen;
    do_reset();
    place_at(4, 6, lat, seen);
    model_place(4, 6, 1'b0);
    place_at(4, 6, lat, seen);
    n_checks++; if (seen) begin n_fail++; $display("FAIL occ_busy: got busy 1 want 0"); end
    n_checks++; if (turn !== 1'b1 || board !== exp_board) begin
      n_fail++; $display("FAIL occ_state: got turn %b board %h want turn 1", turn, board);
    end
    move_to(5, 6);
    pulse(P_PLACE);
    @(negedge Clck);
    @(negedge Clck);
    n_checks++; if (busy !== 1'b1 || dbg_state !== S_SCAN) begin
      n_fail++; $display("FAIL midscan: got busy %b state %0d want 1/%0d", busy, dbg_state, S_SCAN);
    end
    Reset = 1'b1;
    @(negedge Clck);
    Reset = 1'b0;
    n_checks++; if (board !== all_empty || gaming_status !== ST_PLAY || turn !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midscan_reset: got status %b turn %b busy %b board %h", gaming_status, turn, busy, board);
    end
    n_checks++; if (pointer_loc_x !== 4'd4 || pointer_loc_y !== 4'd6 || dbg_state !== S_IDLE) begin
      n_fail++; $display("FAIL midscan_reset_ptr: got (%0d,%0d) state %0d want (4,6) 0", pointer_loc_x, pointer_loc_y, dbg_state);
    end
    exp_board = all_empty;
    exp_x = 4;
    exp_y = 6;
    exp_turn = 1'b0;
  endtask

  task automatic test_draw();
    int lat;
    bit seen;
    int n_bad = 0;
    int n_early = 0;
    int bx, wx;
    int order_x[4];
    logic [1:0] exp_status;
    logic       exp_end_turn;
    do_reset();
    for (int y = 0; y < 16; y++) begin
      for (int k = 0; k < 4; k++) begin
        bx = 4*k + (y % 2) * 2;
        wx = 4*k + (1 - y % 2) * 2;
        order_x[0] = bx;
        order_x[1] = wx;
        order_x[2] = bx + 1;
        order_x[3] = wx + 1;
        for (int j = 0; j < 4; j++) begin
          if (gaming_status !== ST_PLAY) n_early++;
          place_at(order_x[j], y, lat, seen);
          if (!seen || lat < 1 || lat > 35) n_bad++;
          model_place(order_x[j], y, 1'b0);
        end
      end
    end
`ifdef FIVE_SONS_DRAW_DETECT_EN
    exp_status = ST_DRAW;
    exp_end_turn = 1'b1;
`else
    exp_status = ST_PLAY;
    exp_end_turn = 1'b0;
`endif
    n_checks++; if (n_bad != 0 || n_early != 0) begin
      n_fail++; $display("FAIL draw_fill: got %0d bad placements %0d early status want 0/0", n_bad, n_early);
    end
    n_checks++; if (board !== exp_board) begin n_fail++; $display("FAIL draw_board: got %h want %h", board, exp_board); end
    n_checks++; if (gaming_status !== exp_status) begin n_fail++; $display("FAIL draw_status: got %b want %b", gaming_status, exp_status); end
    n_checks++; if (turn !== exp_end_turn) begin n_fail++; $display("FAIL draw_turn: got %b want %b", turn, exp_end_turn); end
    place_at(0, 0, lat, seen);
    n_checks++; if (seen || board !== exp_board) begin n_fail++; $display("FAIL full_place_ignored: got busy %b", seen); end
  endtask

  initial begin
    all_empty = '1;
    exp_board = all_empty;
    test_reset();
    test_pointer();
    test_black_row_win();
    test_diag_white_win();
    test_edge_run();
    test_occupied_and_reset();
    test_draw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
